// File: rtl/cu_pkg.sv
// Shared compute-unit package: FSM state encoding and default datapath widths.
package cu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam int DWIDTH_DEF = 16;
  localparam int AWIDTH_DEF = 24;
  localparam int CWIDTH_DEF = 8;

endpackage

// File: rtl/psum_accum.sv
// Accumulates cfg_len signed psum beats per job and hands one result downstream.
// Define PSUM_ACCUM_RELU_EN to clamp negative results to zero at the output register.
module psum_accum
  import cu_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int CWIDTH = CWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [CWIDTH-1:0] cfg_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] psum_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [AWIDTH-1:0] out_data,
  output logic              busy
);

  state_t state, next_state;

  logic signed [AWIDTH-1:0] acc;
  logic signed [AWIDTH-1:0] sum;
  logic signed [AWIDTH-1:0] result;
  logic [CWIDTH-1:0]        cnt;
  logic [CWIDTH-1:0]        len;
  logic                     beat;
  logic                     last;

  assign beat = in_valid && in_ready;
  assign last = beat && (cnt == len - CWIDTH'(1));
  assign sum  = acc + AWIDTH'($signed(psum_in));

  // The clamp only shapes what gets registered out; acc itself never saturates.
  always_comb begin
    result = sum;
`ifdef PSUM_ACCUM_RELU_EN
    if (sum[AWIDTH-1]) begin
      result = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = (cfg_len == '0) ? OUT : ACC;
        end
      end
      ACC: begin
        if (last) begin
          next_state = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ACC);
    out_valid = (state == OUT);
    busy      = (state != IDLE);
  end

  // An empty job still produces a zero result, so out_data is cleared on that start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc      <= '0;
      cnt      <= '0;
      len      <= '0;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len <= cfg_len;
            acc <= '0;
            cnt <= '0;
            if (cfg_len == '0) begin
              out_data <= '0;
            end
          end
        end
        ACC: begin
          if (last) begin
            out_data <= result;
            acc      <= '0;
            cnt      <= '0;
          end else if (beat) begin
            acc <= sum;
            cnt <= cnt + CWIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_accum.sv
// Directed bench for psum_accum: a 24-bit and a 16-bit accumulator share stimulus
// and are checked every cycle against a transaction-level model plus literal values.
module tb_psum_accum;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               start = 1'b0;
  logic [7:0]         cfg_len = '0;
  logic               in_valid = 1'b0;
  logic signed [15:0] psum_in = '0;
  logic               out_ready = 1'b0;

  logic               in_ready24, out_valid24, busy24;
  logic signed [23:0] out_data24;
  logic               in_ready16, out_valid16, busy16;
  logic signed [15:0] out_data16;

  int errors = 0;
  int checks = 0;

  // Model: exact running sum, widths applied only when predicting out_data.
  int     m_mode = 0;
  int     m_need = 0;
  int     m_got = 0;
  longint m_sum = 0;
  longint m_result = 0;

  psum_accum #(.DWIDTH(16), .AWIDTH(24), .CWIDTH(8)) dut (
    .clk(clk), .rstn(rstn), .start(start), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready24), .psum_in(psum_in),
    .out_valid(out_valid24), .out_ready(out_ready), .out_data(out_data24),
    .busy(busy24)
  );

  psum_accum #(.DWIDTH(16), .AWIDTH(16), .CWIDTH(8)) dut16 (
    .clk(clk), .rstn(rstn), .start(start), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready16), .psum_in(psum_in),
    .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16),
    .busy(busy16)
  );

  always #5 clk = ~clk;

  function automatic longint fix(longint v, int w);
    longint m;
    m = v & ((64'sd1 <<< w) - 64'sd1);
    if (m >= (64'sd1 <<< (w - 1))) m = m - (64'sd1 <<< w);
`ifdef PSUM_ACCUM_RELU_EN
    if (m < 0) m = 0;
`endif
    return m;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d, want %0d", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input int len, input logic v,
                               input int p, input logic rdy);
    start     = s;
    cfg_len   = 8'(len);
    in_valid  = v;
    psum_in   = 16'(p);
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_mode = 0; m_need = 0; m_got = 0; m_sum = 0; m_result = 0;
    end else begin
      case (m_mode)
        0: if (start) begin
             if (cfg_len == 0) begin
               m_result = 0; m_mode = 2;
             end else begin
               m_need = int'(cfg_len); m_got = 0; m_sum = 0; m_mode = 1;
             end
           end
        1: if (in_valid) begin
             m_sum = m_sum + longint'(psum_in);
             m_got++;
             if (m_got == m_need) begin
               m_result = m_sum; m_mode = 2;
             end
           end
        default: if (out_ready) m_mode = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    checkOutput("in_ready24",  longint'(in_ready24),  longint'(m_mode == 1));
    checkOutput("out_valid24", longint'(out_valid24), longint'(m_mode == 2));
    checkOutput("busy24",      longint'(busy24),      longint'(m_mode != 0));
    checkOutput("out_data24",  longint'(out_data24),  fix(m_result, 24));
    checkOutput("in_ready16",  longint'(in_ready16),  longint'(m_mode == 1));
    checkOutput("out_valid16", longint'(out_valid16), longint'(m_mode == 2));
    checkOutput("busy16",      longint'(busy16),      longint'(m_mode != 0));
    checkOutput("out_data16",  longint'(out_data16),  fix(m_result, 16));
  end

  longint relu_m93, relu_m5, relu_wrap;

  initial begin
`ifdef PSUM_ACCUM_RELU_EN
    relu_m93 = 0; relu_m5 = 0; relu_wrap = 0;
`else
    relu_m93 = -93; relu_m5 = -5; relu_wrap = -32768;
`endif
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out_data", longint'(out_data24), 0);
    checkOutput("reset_out_valid", longint'(out_valid24), 0);
    checkOutput("reset_in_ready", longint'(in_ready24), 0);
    checkOutput("reset_busy", longint'(busy24), 0);
    rstn = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);

    // basic job
    applyStimulus(1, 4, 0, 0, 1);
    applyStimulus(0, 0, 1, 10, 1);
    applyStimulus(0, 0, 1, -3, 1);
    applyStimulus(0, 0, 1, 100, 1);
    applyStimulus(0, 0, 1, -200, 1);
    checkOutput("basic_valid", longint'(out_valid24), 1);
    checkOutput("basic_data", longint'(out_data24), relu_m93);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("basic_busy_drop", longint'(busy24), 0);

    // bubbles and back-pressure
    applyStimulus(1, 3, 0, 0, 0);
    applyStimulus(0, 0, 1, 32767, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 32767, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 32767, 0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_hold_data", longint'(out_data24), 98301);
      checkOutput("bp_hold_valid", longint'(out_valid24), 1);
      applyStimulus(0, 0, 0, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("bp_done", longint'(busy24), 0);

    // wrap on the 16-bit accumulator
    applyStimulus(1, 2, 0, 0, 0);
    applyStimulus(0, 0, 1, 32767, 0);
    applyStimulus(0, 0, 1, 1, 0);
    checkOutput("wrap16_data", longint'(out_data16), relu_wrap);
    checkOutput("wrap24_data", longint'(out_data24), 32768);
    applyStimulus(0, 0, 0, 0, 1);

    // empty job
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("len0_valid", longint'(out_valid24), 1);
    checkOutput("len0_data", longint'(out_data24), 0);
    applyStimulus(0, 0, 0, 0, 1);

    // single-beat job
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, -5, 0);
    checkOutput("len1_data", longint'(out_data24), relu_m5);
    applyStimulus(0, 0, 0, 0, 1);

    // start abuse during ACC, OUT and the handshake cycle
    applyStimulus(1, 2, 0, 0, 0);
    applyStimulus(1, 9, 1, 5, 0);
    applyStimulus(1, 0, 1, 6, 0);
    applyStimulus(1, 3, 0, 0, 0);
    checkOutput("abuse_data", longint'(out_data24), 11);
    applyStimulus(1, 3, 0, 0, 1);
    checkOutput("abuse_idle", longint'(busy24), 0);
    applyStimulus(0, 0, 0, 0, 0);

    // reset mid-job, then a clean job
    applyStimulus(1, 4, 0, 0, 0);
    applyStimulus(0, 0, 1, 50, 0);
    applyStimulus(0, 0, 1, 60, 0);
    rstn = 1'b0;
    #1;
    checkOutput("rst_mid_busy", longint'(busy24), 0);
    checkOutput("rst_mid_in_ready", longint'(in_ready24), 0);
    checkOutput("rst_mid_data", longint'(out_data24), 0);
    applyStimulus(0, 0, 0, 0, 0);
    rstn = 1'b1;
    applyStimulus(1, 2, 0, 0, 0);
    applyStimulus(0, 0, 1, 7, 0);
    applyStimulus(0, 0, 1, 8, 0);
    checkOutput("post_rst_data", longint'(out_data24), 15);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/psum_accum.md
Name: psum_accum

Overview:
- Downstream consumer of the 1x1 PE's registered signed psum.
- Accumulates a programmed number of psum beats (one per input channel) into a wide accumulator.
- Emits one result per job over a valid/ready handshake to the output buffer / requant stage.
- Sequencing: control pulses start with the job length, then streams psums with in_valid.

Parameters:
- DWIDTH, 16, width of signed psum from PE.
- AWIDTH, 24, width of signed accumulator and result; must be >= DWIDTH.
- CWIDTH, 8, width of beat counter and cfg_len.

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  job start pulse; honoured only in IDLE.
- cfg_len  input  CWIDTH  number of psum beats in the job; sampled with start.
- in_valid  input  1  psum_in valid.
- in_ready  output  1  block accepts psum_in this cycle.
- psum_in  input  DWIDTH  signed psum from PE.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_data  output  AWIDTH  signed accumulated result.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Clock/reset: single clock clk; rstn asynchronous, active-low. Reset clears state to IDLE, acc=0, cnt=0, len=0, out_data=0, out_valid=0. in_ready=0 and busy=0 follow from IDLE.
- Reset mid-job: the job is discarded, with no partial output.
- States: IDLE, ACC, OUT. in_ready=1 only in ACC. out_valid=1 only in OUT.
- IDLE, start=1, cfg_len>=1: latch len=cfg_len, acc=0, cnt=0, go to ACC.
- IDLE, start=1, cfg_len=0: go straight to OUT with out_data=0 (empty job still yields one result).
- start outside IDLE is ignored, with no effect on the running job.
- ACC: a beat transfers when in_valid && in_ready.
  - Each beat: acc <= acc + sign_extend(psum_in) to AWIDTH; cnt <= cnt+1.
  - No beat: hold state.
- Last beat (cnt==len-1): out_data <= acc + sext(psum_in), registered; out_valid=1 next cycle; state OUT. acc and cnt reset to 0.
  - Latency: result visible the cycle after the last accepted beat.
- OUT: out_data and out_valid are held stable until out_valid && out_ready.
  - Then go to IDLE, out_valid=0; out_data retains its last value.
  - A start in the same cycle as the OUT handshake is ignored; start becomes honourable the following cycle.
- Arithmetic: two's complement, wraps modulo 2^AWIDTH; no overflow flag. Sign extension of psum_in is mandatory.
- Throughput: one beat per cycle in ACC. Minimum job turnaround is len+2 cycles when out_ready is held high.

Optional Feature:
- Macro: PSUM_ACCUM_RELU_EN.
- Defined: the value registered into out_data on the last beat is clamped to 0 if negative. acc itself stays unclamped during accumulation.
- Undefined: out_data is the raw signed sum.
- No port changes either way.

Decomposition:
- Shared package (cu_pkg): state enum (IDLE, ACC, OUT) and default width constants for DWIDTH, AWIDTH, CWIDTH, used by the PE array and downstream stages.
- Single flat module: counter, accumulator and FSM are small and tightly coupled, so no sub-module.

Test Plan:
- Basic job: start, cfg_len=4; psums 10, -3, 100, -200 on consecutive cycles, out_ready=1 -> out_valid one cycle after the 4th beat, out_data=-93 (with RELU_EN: 0); busy drops the cycle after the handshake.
- Bubbles and back-pressure: cfg_len=3, in_valid gapped (1,0,1,0,1) with psums 32767, 32767, 32767, out_ready=0 for 5 cycles.
  - Required: in_ready stays high only in ACC.
  - Required: out_data=98301 is held stable while out_ready=0.
  - Required: completion only when out_ready=1.
- Wrap: AWIDTH=16 build, cfg_len=2, psums 32767 and 1 -> out_data=-32768.
- Edge lengths:
  - cfg_len=0 -> out_valid the next cycle with out_data=0.
  - cfg_len=1 with psum -5 -> out_data=-5 (RELU_EN: 0).
- start abuse: start pulsed during ACC and during OUT (including the handshake cycle) -> ignored; the result equals the original job's sum.
- Reset mid-job: assert rstn=0 after 2 of 4 beats -> all outputs 0 immediately; a new job of 2 beats (7, 8) -> out_data=15 with no residue.
